// File: rtl/order_scheduler.sv
// Round-robin scheduler that shares one matching engine between NUM_REQ order sources.
// Optional build macro SELL_PRIORITY_EN: pending sells are arbitrated ahead of buys.
module order_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int PRICE_W = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk_50,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_side,
  input  logic [NUM_REQ*PRICE_W-1:0] req_price,
  input  logic                       halt,
  input  logic                       eng_ready,
  input  logic                       eng_done,
  input  logic                       eng_match,
  output logic                       ord_valid,
  output logic                       ord_side,
  output logic [PRICE_W-1:0]         ord_price,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         ack,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [7:0]                 match_total
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     rr_ptr_reg;
  logic [IDX_W-1:0]     idx_reg;
  logic                 side_reg;
  logic [PRICE_W-1:0]   price_reg;
  logic [NUM_REQ-1:0]   grant_reg;
  logic [NUM_REQ-1:0]   ack_reg;
  logic [7:0]           cnt_reg;
  logic [7:0]           match_reg;
  logic                 terr_reg;

  logic [IDX_W:0]       pick;
  logic                 pick_found;
  logic [IDX_W-1:0]     pick_idx;
  logic [PRICE_W-1:0]   price_arr [NUM_REQ];
  logic                 timed_out;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_price
      assign price_arr[gi] = req_price[gi*PRICE_W +: PRICE_W];
    end
  endgenerate

  // Returns {found, index} of the first set mask bit after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] mask,
                                             input logic [IDX_W-1:0]   ptr);
    logic             found;
    logic [IDX_W-1:0] idx;
    logic [NUM_REQ-1:0] sh;
    int               j;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j  = (int'(ptr) + k) % NUM_REQ;
      sh = mask >> j;
      if (!found && sh[0]) begin
        found = 1'b1;
        idx   = IDX_W'(j);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    pick = '0;
`ifdef SELL_PRIORITY_EN
    pick = rr_pick(req & ~req_side, rr_ptr_reg);
    if (!pick[IDX_W])
      pick = rr_pick(req, rr_ptr_reg);
`else
    pick = rr_pick(req, rr_ptr_reg);
`endif
  end

  assign pick_found = pick[IDX_W];
  assign pick_idx   = pick[IDX_W-1:0];
  assign timed_out  = (cnt_reg == 8'(TIMEOUT - 1));

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (pick_found && !halt) state_next = ISSUE;
      // A same-cycle eng_ready beats halt: the handshake has already happened.
      ISSUE:   if (eng_ready) state_next = WAIT;
               else if (halt) state_next = IDLE;
      WAIT:    if (eng_done || timed_out) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ord_valid = (state_reg == ISSUE);
    busy      = (state_reg != IDLE);
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      rr_ptr_reg <= IDX_W'(NUM_REQ - 1);
      idx_reg    <= '0;
      side_reg   <= 1'b0;
      price_reg  <= '0;
      grant_reg  <= '0;
      ack_reg    <= '0;
      cnt_reg    <= '0;
      match_reg  <= '0;
      terr_reg   <= 1'b0;
    end else begin
      ack_reg <= '0;
      cnt_reg <= (state_reg == WAIT) ? cnt_reg + 8'd1 : 8'd0;

      if (state_reg == IDLE && state_next == ISSUE) begin
        idx_reg   <= pick_idx;
        side_reg  <= req_side[pick_idx];
        price_reg <= price_arr[pick_idx];
      end

      if (state_next == IDLE)
        grant_reg <= '0;
      else if (state_reg == IDLE)
        grant_reg <= NUM_REQ'(1) << pick_idx;

      if (state_reg == ISSUE && eng_ready) begin
        ack_reg    <= grant_reg;
        rr_ptr_reg <= idx_reg;
      end

      if (state_reg == WAIT) begin
        if (eng_done) begin
          if (eng_match && match_reg != 8'hFF)
            match_reg <= match_reg + 8'd1;
        end else if (timed_out) begin
          terr_reg <= 1'b1;
        end
      end
    end
  end

  assign ord_side    = side_reg;
  assign ord_price   = price_reg;
  assign grant       = grant_reg;
  assign ack         = ack_reg;
  assign timeout_err = terr_reg;
  assign match_total = match_reg;

endmodule

// File: doc/order_scheduler.md
Name: order_scheduler

Overview:
- Round-robin scheduler that shares the single matching engine between NUM_REQ order sources (generator, keypad, replay, test injector).
- Selects one pending order and latches its side and price.
- Presents the order to the engine with a valid/ready handshake, then waits for the engine's result.
- Honours the trade-limit halt from the trade counter and flags engine timeouts.

Parameters:
NUM_REQ, 4, number of requesters
PRICE_W, 8, price width in bits
TIMEOUT, 15, max cycles in WAIT before abort (1..255)

Ports:
clk_50  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester order pending (level)
req_side  in  NUM_REQ  per-requester side: 1 = buy, 0 = sell
req_price  in  NUM_REQ*PRICE_W  requester i at bits [i*PRICE_W +: PRICE_W]
halt  in  1  block new grants (trade limit reached)
eng_ready  in  1  engine accepts an order this cycle
eng_done  in  1  one-cycle engine result strobe
eng_match  in  1  trade occurred; valid only with eng_done
ord_valid  out  1  order presented to the engine
ord_side  out  1  latched side
ord_price  out  PRICE_W  latched price
grant  out  NUM_REQ  one-hot owner of the current order; 0 in IDLE
ack  out  NUM_REQ  one-cycle pulse: requester's order accepted
busy  out  1  state != IDLE
timeout_err  out  1  sticky; set on engine timeout
match_total  out  8  completed matches, saturates at 255

Behaviour:
- Reset: state = IDLE; all outputs 0; rr_ptr = NUM_REQ-1, so requester 0 wins first.
- State IDLE: if any req and !halt, pick the first set req scanning rr_ptr+1 upward with wrap.
  - Same clock edge: latch ord_side and ord_price, set grant, go to ISSUE.
  - ord_valid is high the cycle after req is seen (1-cycle latency).
- State ISSUE: ord_valid = 1; ord_side, ord_price and grant are held stable.
  - Handshake occurs on the edge where ord_valid && eng_ready; that edge goes to WAIT.
  - ack[granted] pulses for exactly the next cycle.
  - rr_ptr <= granted index at the handshake.
  - If halt is sampled high in ISSUE before the handshake, the order is withdrawn: go to IDLE, no ack, rr_ptr unchanged.
  - If halt and eng_ready are high in the same cycle, the handshake wins.
- State WAIT: ord_valid = 0; grant held; timeout counter increments each cycle.
  - On eng_done: if eng_match, increment match_total (saturating); go to IDLE.
  - If the counter reaches TIMEOUT without eng_done: set timeout_err, go to IDLE, no count.
  - halt has no effect in WAIT; an in-flight order always completes.
- Rules in every state:
  - eng_done outside WAIT is ignored.
  - A requester dropping req after it is granted does not cancel its order; the latched values are used.
  - The scheduler returns to IDLE for at least one cycle between orders, so the max rate is one order per 3 cycles plus engine latency.
  - No requester waits more than NUM_REQ-1 completed orders while its req is held.
- Reset asserted mid-operation: all outputs go to reset values immediately; no ack is emitted.
- timeout_err clears only on reset.

Optional Feature:
- Macro: SELL_PRIORITY_EN.
- Defined: in IDLE, requesters with req && !req_side (sell) are considered before buy requesters. Round-robin order from rr_ptr+1 is kept within each class. Buy requesters are served only when no sell is pending.
- Undefined: pure round-robin, side ignored for arbitration.

Test Plan:
- Single order: req=0001, side=1, price=0x42; eng_ready high -> ord_valid at cycle 1; ord_price=0x42, ord_side=1; ack=0001 next cycle; eng_done+eng_match -> match_total=1, back to IDLE.
- Fairness: req=1111 held; engine acks immediately, done 2 cycles later -> grant sequence 0001, 0010, 0100, 1000, 0001.
- Halt: halt=1 with req=0010 -> grant stays 0; raise halt during ISSUE with eng_ready=0 -> ord_valid drops, no ack, next grant after halt=0 is still 0010.
- Timeout: eng_done never asserted in WAIT -> after 15 cycles timeout_err=1, IDLE, match_total unchanged; next request is still served.
- Saturation and reset: 256 matching orders -> match_total=255; assert reset in WAIT -> all outputs 0 asynchronously, next grant goes to requester 0.
- SELL_PRIORITY_EN: req=0011, side=01 (req0 buy, req1 sell) -> first grant 0010; with macro off -> first grant 0001.
